// File: rtl/saw_seq_pkg.sv
// Shared types and constants for the sawtooth note sequencer.
package saw_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pattern entry layout: {sel[1:0], dur[DUR_W-1:0]}
  localparam int DUR_W   = 8;
  localparam int SEL_W   = 2;
  localparam int SEL_LSB = DUR_W;

  // Default silence after each note, in ticks (must be >= 1)
  localparam int GAP_TICKS_DEF = 4;

endpackage

// File: rtl/saw_tick_div.sv
// Loadable modulo-(div+1) tick divider; tick fires on the last count of each period.
module saw_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] div_l_reg;

  // Period latch and free-running counter; clr wins over load so an abort never arms a new period
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg   <= '0;
      div_l_reg <= '0;
    end else if (load) begin
      cnt_reg   <= '0;
      div_l_reg <= div_in;
    end else if (en) begin
      cnt_reg <= (cnt_reg == div_l_reg) ? '0 : cnt_reg + DIV_W'(1);
    end
  end

  assign tick = en && (cnt_reg == div_l_reg);

endmodule

// File: rtl/saw_seq_ctrl.sv
// Note-pattern sequencer driving the saw generator's clk_en/dc/dc_sel inputs.
module saw_seq_ctrl #(
  parameter  int DEPTH     = 8,
  parameter  int DUR_W     = saw_seq_pkg::DUR_W,
  parameter  int DIV_W     = 16,
  parameter  int GAP_TICKS = saw_seq_pkg::GAP_TICKS_DEF,
  localparam int AW        = $clog2(DEPTH),
  localparam int EW        = DUR_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [DIV_W-1:0] div,
  input  logic [AW-1:0]    len,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [EW-1:0]    wr_data,
  output logic             clk_en,
  output logic             dc,
  output logic [1:0]       dc_sel,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    idx
);

  import saw_seq_pkg::*;

  localparam int GW = $clog2(GAP_TICKS + 1);

  state_t            state_reg, state_next;
  logic [EW-1:0]     mem_reg [DEPTH];
  logic [AW-1:0]     len_reg;
  logic              loop_reg;
  logic [AW-1:0]     idx_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DUR_W-1:0]  note_cnt_reg;
  logic [GW-1:0]     gap_cnt_reg;

  logic              run;
  logic              tick;
  logic              start_ok;
  logic              last_note;
  logic              last_gap;
  logic              more;
  logic [AW-1:0]     next_idx;
  logic [EW-1:0]     entry0;
  logic [EW-1:0]     next_entry;

  // A zero duration still plays for one tick
  function automatic logic [DUR_W-1:0] dur_min1(input logic [EW-1:0] e);
    return (e[DUR_W-1:0] == '0) ? DUR_W'(1) : e[DUR_W-1:0];
  endfunction

  assign run       = (state_reg == ST_PLAY) || (state_reg == ST_GAP);
  assign start_ok  = (state_reg == ST_IDLE) && start && !stop;
  assign last_note = tick && (note_cnt_reg == DUR_W'(1));
  assign last_gap  = tick && (gap_cnt_reg == GW'(1));
  assign more      = (idx_reg != len_reg) || loop_reg;
  assign next_idx  = (idx_reg == len_reg) ? '0 : idx_reg + AW'(1);
  // Same-cycle write to entry 0 bypasses into the first note
  assign entry0     = (wr_en && (wr_addr == '0)) ? wr_data : mem_reg[0];
  assign next_entry = mem_reg[next_idx];

  saw_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (stop),
    .load   (start_ok),
    .div_in (div),
    .en     (run),
    .tick   (tick)
  );

  // Pattern register file: cleared by reset, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en && (state_reg == ST_IDLE)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) mem_reg[i] <= wr_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic; stop overrides every transition
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start)     state_next = ST_PLAY;
        ST_PLAY: if (last_note) state_next = ST_GAP;
        ST_GAP:  if (last_gap)  state_next = more ? ST_PLAY : ST_DONE;
        ST_DONE:                state_next = ST_IDLE;
        default:                state_next = ST_IDLE;
      endcase
    end
  end

  // Playback datapath: latched controls, entry index, note and gap counters
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      len_reg      <= '0;
      loop_reg     <= 1'b0;
      idx_reg      <= '0;
      sel_reg      <= '0;
      note_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg      <= len;
            loop_reg     <= loop;
            idx_reg      <= '0;
            sel_reg      <= entry0[DUR_W +: SEL_W];
            note_cnt_reg <= dur_min1(entry0);
          end
        end
        ST_PLAY: begin
          if (last_note)  gap_cnt_reg  <= GW'(GAP_TICKS);
          else if (tick)  note_cnt_reg <= note_cnt_reg - DUR_W'(1);
        end
        ST_GAP: begin
          if (last_gap) begin
            if (more) begin
              idx_reg      <= next_idx;
              sel_reg      <= next_entry[DUR_W +: SEL_W];
              note_cnt_reg <= dur_min1(next_entry);
            end else begin
              idx_reg <= '0;
            end
          end else if (tick) begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    busy   = run;
    clk_en = tick;
    dc     = (state_reg == ST_PLAY);
    dc_sel = run ? sel_reg : 2'd0;
    done   = (state_reg == ST_DONE);
    idx    = idx_reg;
  end

endmodule

// File: tb/tb_saw_seq_ctrl.sv
// Directed testbench for saw_seq_ctrl with hand-derived per-cycle expectations.
module tb_saw_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        loop;
  logic [15:0] div;
  logic [2:0]  len;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [9:0]  wr_data;
  logic        clk_en;
  logic        dc;
  logic [1:0]  dc_sel;
  logic        busy;
  logic        done;
  logic [2:0]  idx;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int div_v  = 0;

  always #5 clk = ~clk;

  saw_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .div     (div),
    .len     (len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clk_en  (clk_en),
    .dc      (dc),
    .dc_sel  (dc_sel),
    .busy    (busy),
    .done    (done),
    .idx     (idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Observed vector layout: {clk_en, dc, dc_sel[1:0], busy, done, idx[2:0]}
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {clk_en, dc, dc_sel, busy, done, idx};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b ({ce,dc,sel,busy,done,idx})", tag, cyc, obs, exp);
    end
    $display("[TB] %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
  endtask

  // n busy cycles with fixed dc/dc_sel/idx; tick expected on the last count of each period
  task automatic seg(input string tag, input logic e_dc, input logic [1:0] e_sel,
                     input logic [2:0] e_idx, input int n);
    logic e_ce;
    for (int k = 0; k < n; k++) begin
      e_ce = (((cyc - 1) % (div_v + 1)) == div_v);
      chk(tag, {e_ce, e_dc, e_sel, 1'b1, 1'b0, e_idx});
      step();
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 9'b0_0_00_0_1_000);
    step();
    chk({tag, "_idle"}, 9'b0);
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk(tag, 9'b0);
      step();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] s, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {s, d};
    step();
    wr_en   = 1'b0;
  endtask

  task automatic go(input int d, input logic [2:0] l, input logic lp);
    div   = 16'(d);
    div_v = d;
    len   = l;
    loop  = lp;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    div = '0; len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    rst = 1'b0;
    check_idle("reset", 2);

    // Single note, div=1: ticks at 2,4,6; gap 7..14; done at 15
    wr(3'd0, 2'd2, 8'd3);
    go(1, 3'd0, 1'b0);
    seg("t1_play", 1'b1, 2'd2, 3'd0, 6);
    seg("t1_gap", 1'b0, 2'd2, 3'd0, 8);
    check_done("t1");

    // Three notes, div=0
    wr(3'd0, 2'd0, 8'd1);
    wr(3'd1, 2'd1, 8'd2);
    wr(3'd2, 2'd3, 8'd1);
    go(0, 3'd2, 1'b0);
    seg("t2_n0", 1'b1, 2'd0, 3'd0, 1);
    seg("t2_g0", 1'b0, 2'd0, 3'd0, 4);
    seg("t2_n1", 1'b1, 2'd1, 3'd1, 2);
    seg("t2_g1", 1'b0, 2'd1, 3'd1, 4);
    seg("t2_n2", 1'b1, 2'd3, 3'd2, 1);
    seg("t2_g2", 1'b0, 2'd3, 3'd2, 4);
    check_done("t2");
    step();
    chk("t2_single_done", 9'b0);

    // Loop over two entries, then stop mid-gap
    go(0, 3'd1, 1'b1);
    seg("t3_n0", 1'b1, 2'd0, 3'd0, 1);
    seg("t3_g0", 1'b0, 2'd0, 3'd0, 4);
    seg("t3_n1", 1'b1, 2'd1, 3'd1, 2);
    seg("t3_g1", 1'b0, 2'd1, 3'd1, 4);
    seg("t3_wrap", 1'b1, 2'd0, 3'd0, 1);
    seg("t3_g0b", 1'b0, 2'd0, 3'd0, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("t3_stop", 6);

    // dur=0 plays one tick
    wr(3'd0, 2'd1, 8'd0);
    go(0, 3'd0, 1'b0);
    seg("t4_play", 1'b1, 2'd1, 3'd0, 1);
    seg("t4_gap", 1'b0, 2'd1, 3'd0, 4);
    check_done("t4");

    // Write during PLAY is dropped; replay shows old entry
    go(0, 3'd0, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = {2'd3, 8'd5};
    seg("t5_play", 1'b1, 2'd1, 3'd0, 1);
    wr_en = 1'b0;
    seg("t5_gap", 1'b0, 2'd1, 3'd0, 4);
    check_done("t5");
    go(0, 3'd0, 1'b0);
    seg("t5_rb_play", 1'b1, 2'd1, 3'd0, 1);
    seg("t5_rb_gap", 1'b0, 2'd1, 3'd0, 4);
    check_done("t5_rb");

    // start and write to entry 0 in the same IDLE cycle
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = {2'd2, 8'd2};
    go(0, 3'd0, 1'b0);
    wr_en = 1'b0;
    seg("t6_play", 1'b1, 2'd2, 3'd0, 2);
    seg("t6_gap", 1'b0, 2'd2, 3'd0, 4);
    check_done("t6");

    // Reset mid-PLAY clears state and pattern
    wr(3'd0, 2'd3, 8'd5);
    go(0, 3'd0, 1'b0);
    seg("t7_play", 1'b1, 2'd3, 3'd0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("t7_rst", 2);
    go(0, 3'd0, 1'b0);
    seg("t7_cleared", 1'b1, 2'd0, 3'd0, 1);
    seg("t7_gap", 1'b0, 2'd0, 3'd0, 4);
    check_done("t7");

    // start with stop in IDLE stays idle
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_idle("t8_startstop", 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/saw_seq_ctrl.md
# saw_seq_ctrl

Sequencer that plays a short programmed note pattern on the sawtooth generator. It drives the generator's `clk_en`, `dc` and `dc_sel` inputs and steps through up to DEPTH stored entries. Each entry gives a pitch step select and a duration, and notes are separated by a silent gap. The block sits between the control/register logic and the saw generator, and owns the generator's enable pacing.

## Interface
- DEPTH, 8: number of pattern entries (power of 2).
- DUR_W, 8: duration field width, in ticks.
- DIV_W, 16: tick divider width.
- GAP_TICKS, 4: ticks of silence after each note; must be ≥1.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin playback; honoured only in IDLE.
- stop  in  1  abort playback; wins over start.
- loop  in  1  repeat the pattern after the last entry; latched at start.
- div  in  DIV_W  tick period minus 1; latched at start.
- len  in  log2(DEPTH)  index of the last entry to play; latched at start.
- wr_en  in  1  pattern write strobe; ignored while busy.
- wr_addr  in  log2(DEPTH)  pattern write address.
- wr_data  in  2+DUR_W  entry: [DUR_W+1:DUR_W] = dc_sel, [DUR_W-1:0] = duration.
- clk_en  out  1  generator advance strobe (tick).
- dc  out  1  generator gate: 1 = ramp, 0 = hold at minimum on tick.
- dc_sel  out  2  generator step select for the current note.
- busy  out  1  high in PLAY and GAP.
- done  out  1  one-cycle pulse at normal completion.
- idx  out  log2(DEPTH)  current entry index.

## Operation
- States: IDLE, PLAY, GAP, DONE.
- Outputs decode from registers only; there is no combinational path from an input to an output.
- IDLE: clk_en = dc = busy = done = 0, dc_sel = 0, idx = 0.
  - start=1 and stop=0: latch div, len, loop. Set idx=0 and tick counter = 0. Load the note counter from entry 0. Next state is PLAY.
- Tick counter: runs in PLAY and GAP, counting 0..div_l, then wraps to 0. clk_en=1 when count==div_l. div=0 gives clk_en every cycle. The counter is not cleared between notes.
- PLAY: dc=1 and dc_sel = mem[idx].sel.
  - The note lasts max(dur,1) ticks; dur=0 plays for 1 tick.
  - On the last note tick, go to GAP and load the gap counter with GAP_TICKS.
- GAP: dc=0, dc_sel holds the last note's value, clk_en continues.
  - On the last gap tick:
    - idx≠len_l: idx+1, go to PLAY, load the next duration.
    - idx==len_l and loop_l=1: idx=0, go to PLAY.
    - Otherwise: go to DONE.
- DONE: exactly one cycle with done=1 and busy=0. Next state is IDLE.
- stop=1 in any state: IDLE next cycle, with all outputs as in IDLE. No done pulse is generated.
- rst has the same effect as stop. It also clears all pattern entries to 0.
- Pattern memory:
  - A write in IDLE updates the entry at the clock edge.
  - start and wr_en in the same cycle: the write lands, and PLAY reads the new value.
  - wr_en while busy or in DONE is dropped.
- The generator itself is not reset by this block. Between notes it is held at its minimum by dc=0 during GAP ticks.

## Timing
- Start latency: start at cycle 0 gives PLAY in cycle 1. The first clk_en is in cycle 1+div.
- Note i occupies exactly max(dur_i,1)×(div+1) cycles, except note 0, which is aligned from PLAY entry.
- Every gap occupies GAP_TICKS×(div+1) cycles.
- Done timing: with the final gap tick in cycle T, done=1 in cycle T+1 and IDLE is entered in T+2. start is accepted again in T+2.
- start held high is sampled only in IDLE. There is no re-trigger during busy or DONE.
- State, idx, dc and dc_sel change on the cycle after the tick that caused the change. The tick cycle itself still shows the old values.

## Structure
- Package saw_seq_pkg holds:
  - the state enum;
  - entry field offsets and widths (SEL_LSB, DUR_W);
  - the GAP_TICKS default.
- One sub-module, saw_tick_div:
  - loadable modulo-(div+1) counter;
  - clear input, enable input, tick output.
- The FSM, note/gap counters and pattern register file stay in the top.

## Test plan
- div=1, len=0, entry0 {sel=2, dur=3}, GAP_TICKS=4, start at cycle 0 → ticks at cycles 2,4,6 with dc=1 and dc_sel=2; GAP in cycles 7–14 with ticks at 8,10,12,14; done=1 at 15; busy=0 from 15.
- len=2, entries {0,1},{1,2},{3,1}, div=0 → dc_sel sequence 0 (1 tick), gap 4, 1 (2 ticks), gap 4, 3 (1 tick), gap 4; idx reads 0,1,2; a single done pulse.
- loop=1, len=1 → after entry 1's gap, idx returns to 0 and PLAY resumes. Assert stop mid-GAP → IDLE next cycle, outputs 0, no done.
- Entry dur=0 → plays 1 tick. div=0 → clk_en high every PLAY/GAP cycle.
- wr_en during PLAY → memory unchanged on readback. start plus wr_en to addr 0 in the same IDLE cycle → the new dc_sel appears in the first PLAY cycle.
- rst mid-PLAY → next cycle IDLE, all outputs 0, entries cleared. start+stop together in IDLE → remains IDLE.
